// File: rtl/tone_if.sv
// Note interface between the melody sequencer (master) and the tone generator (slave).
interface tone_if;
  logic [2:0] mode;
  logic [1:0] HL;
  logic       buzz;
  logic       busy;
  logic       note_ack;

  modport master (output mode, HL, input buzz, busy, note_ack);
  modport slave  (input mode, HL, output buzz, busy, note_ack);
endinterface

// File: rtl/tone_gen.sv
// Square-wave buzzer driver: (mode, HL) selects a half-period. A new note is
// adopted only at the end of a full period.
module tone_gen #(
  parameter int unsigned CLK_HZ = 4000000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic   clk,
  input  logic   rst,
  tone_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       cur_mode, cur_mode_nxt;
  logic [1:0]       cur_hl, cur_hl_nxt;
  logic             ack, ack_nxt;
  logic [CNT_W-1:0] half_tab [32];
  logic [CNT_W-1:0] half_in, half_cur;

  // Half-period for table index {mode, HL}; evaluated only at elaboration.
  function automatic int unsigned half_calc(int unsigned idx);
    int unsigned f;
    int unsigned base;
    case (idx >> 2)
      1:       f = 262;
      2:       f = 294;
      3:       f = 330;
      4:       f = 349;
      5:       f = 392;
      6:       f = 440;
      7:       f = 494;
      default: f = 0;
    endcase
    if (f == 0) return 0;
    base = CLK_HZ / (2 * f);
    case (idx & 3)
      0:       return base * 2;
      1:       return base;
      default: return base >> 1;
    endcase
  endfunction

  for (genvar i = 0; i < 32; i++) begin : g_half
    localparam int unsigned H = half_calc(i);
    assign half_tab[i] = CNT_W'(H);
  end

  assign half_in  = half_tab[{bus.mode, bus.HL}];
  assign half_cur = half_tab[{cur_mode, cur_hl}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_mode <= '0;
      cur_hl   <= 2'b01;
      ack      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_mode <= cur_mode_nxt;
      cur_hl   <= cur_hl_nxt;
      ack      <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cur_mode_nxt = cur_mode;
    cur_hl_nxt   = cur_hl;
    ack_nxt      = 1'b0;
    case (state)
      IDLE: begin
        cur_hl_nxt = bus.HL;
        if (bus.mode != '0) begin
          cur_mode_nxt = bus.mode;
          cnt_nxt      = half_in - ONE;
          ack_nxt      = 1'b1;
          state_nxt    = HIGH;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          cnt_nxt   = half_cur - ONE;
          state_nxt = LOW;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      LOW: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - ONE;
        end else if ({bus.mode, bus.HL} == {cur_mode, cur_hl}) begin
          cnt_nxt   = half_cur - ONE;
          state_nxt = HIGH;
        end else begin
          // Full-period boundary with a different pair: adopt it (rest ends play).
          cur_mode_nxt = bus.mode;
          cur_hl_nxt   = bus.HL;
          ack_nxt      = 1'b1;
          if (bus.mode != '0) begin
            cnt_nxt   = half_in - ONE;
            state_nxt = HIGH;
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        cnt_nxt      = '0;
        cur_mode_nxt = '0;
      end
    endcase
  end

  always_comb begin
    bus.buzz     = (state == HIGH);
    bus.busy     = (state != IDLE);
    bus.note_ack = ack;
  end

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: per-cycle period-position reference model plus directed
// phase-length measurements and randomized note sequences.
module tb_tone_gen;

  localparam int CLK_HZ = 4000000;
  localparam int LIMIT  = 40000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  tone_if bus ();

  tone_gen #(.CLK_HZ(CLK_HZ), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int half_of(int m, int hl);
    int f;
    int base;
    case (m)
      1:       f = 262;
      2:       f = 294;
      3:       f = 330;
      4:       f = 349;
      5:       f = 392;
      6:       f = 440;
      7:       f = 494;
      default: return 0;
    endcase
    base = CLK_HZ / (2 * f);
    if (hl == 0) return base * 2;
    if (hl == 1) return base;
    return base / 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: position within the current full period of the adopted note.
  bit m_play = 1'b0;
  int m_mode = 0;
  int m_hl   = 1;
  int m_pos  = 0;
  bit m_ack  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_play = 1'b0; m_mode = 0; m_hl = 1; m_pos = 0; m_ack = 1'b0;
    end else begin
      m_ack = 1'b0;
      if (!m_play) begin
        m_hl = int'(bus.HL);
        if (bus.mode != 3'd0) begin
          m_play = 1'b1; m_mode = int'(bus.mode); m_pos = 0; m_ack = 1'b1;
        end
      end else begin
        m_pos++;
        if (m_pos == 2 * half_of(m_mode, m_hl)) begin
          m_pos = 0;
          if (int'(bus.mode) != m_mode || int'(bus.HL) != m_hl) begin
            m_ack  = 1'b1;
            m_mode = int'(bus.mode);
            m_hl   = int'(bus.HL);
            if (bus.mode == 3'd0) m_play = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_buzz", 32'(bus.buzz), 32'(m_play && (m_pos < half_of(m_mode, m_hl))));
    check("cyc_busy", 32'(bus.busy), 32'(m_play));
    check("cyc_ack", 32'(bus.note_ack), 32'(m_ack));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    bus.mode = 3'd0;
    rst = 1'b0;
  endtask

  task automatic wait_rise(output int w);
    w = 0;
    while (bus.buzz !== 1'b1 && w < LIMIT) begin step(); w++; end
  endtask

  task automatic count_level(input logic lvl, output int n);
    n = 0;
    while (bus.buzz === lvl && n < LIMIT) begin step(); n++; end
  endtask

  initial begin
    int w, n, n_ack, n_hi;
    bus.mode = 3'd0;
    bus.HL   = 2'b01;
    rst      = 1'b1;
    step();
    step();
    check("rst_buzz", 32'(bus.buzz), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ack", 32'(bus.note_ack), 0);
    rst = 1'b0;

    // Rest held, octave wandering: silent adoption only.
    for (int i = 0; i < 2000; i++) begin
      if (i % 400 == 0) bus.HL = 2'($urandom_range(0, 3));
      step();
    end
    check("idle_busy", 32'(bus.busy), 0);

    // mode 6 middle octave
    bus.HL = 2'b01; bus.mode = 3'd6;
    wait_rise(w);
    check("m6_latency", w, 1);
    check("m6_ack", 32'(bus.note_ack), 1);
    count_level(1'b1, n); check("m6_high", n, 4545);
    count_level(1'b0, n); check("m6_low", n, 4545);
    check("m6_no_reack", 32'(bus.note_ack), 0);
    check("m6_rehigh", 32'(bus.buzz), 1);

    // Octave extremes
    do_reset(); bus.HL = 2'b00; bus.mode = 3'd1;
    wait_rise(w); count_level(1'b1, n); check("m1_low_oct", n, 15266);
    do_reset(); bus.HL = 2'b10; bus.mode = 3'd1;
    wait_rise(w); count_level(1'b1, n); check("m1_high_oct", n, 3816);
    do_reset(); bus.HL = 2'b11; bus.mode = 3'd7;
    wait_rise(w); count_level(1'b1, n); check("m7_high_oct", n, 2024);

    // Note change mid-period waits for the period boundary
    do_reset(); bus.HL = 2'b01; bus.mode = 3'd3;
    wait_rise(w);
    n = 0;
    while (bus.buzz === 1'b1 && n < LIMIT) begin
      if (n == 1000) bus.mode = 3'd5;
      step(); n++;
    end
    check("sw_high", n, 6060);
    count_level(1'b0, n); check("sw_low", n, 6060);
    check("sw_ack", 32'(bus.note_ack), 1);
    count_level(1'b1, n); check("sw_new_high", n, 5102);

    // Glitch that reverts before the boundary is ignored
    n = 0; n_ack = 0;
    while (bus.buzz === 1'b0 && n < LIMIT) begin
      if (n == 100) bus.mode = 3'd4;
      if (n == 110) bus.mode = 3'd5;
      n_ack += int'(bus.note_ack);
      step(); n++;
    end
    check("gl_low", n, 5102);
    check("gl_ack_count", n_ack, 0);
    check("gl_no_ack", 32'(bus.note_ack), 0);
    count_level(1'b1, n); check("gl_high", n, 5102);

    // Rest requested mid-low: low phase completes, then idle
    n = 0; n_hi = 0;
    while (bus.busy === 1'b1 && n < LIMIT) begin
      if (n == 200) bus.mode = 3'd0;
      n_hi += int'(bus.buzz);
      step(); n++;
    end
    check("rest_low", n, 5102);
    check("rest_buzz_hi", n_hi, 0);
    check("rest_ack", 32'(bus.note_ack), 1);
    check("rest_buzz", 32'(bus.buzz), 0);
    step();
    check("rest_ack_once", 32'(bus.note_ack), 0);

    // Asynchronous reset mid-tone, then restart from idle
    bus.HL = 2'b01; bus.mode = 3'd2;
    wait_rise(w);
    repeat (500) step();
    rst = 1'b1;
    #1;
    check("arst_buzz", 32'(bus.buzz), 0);
    check("arst_busy", 32'(bus.busy), 0);
    step();
    step();
    rst = 1'b0;
    wait_rise(w);
    check("arst_latency", w, 1);
    check("arst_ack", 32'(bus.note_ack), 1);
    count_level(1'b1, n); check("arst_high", n, 6802);

    // Randomized note sequence against the reference model
    for (int s = 0; s < 10; s++) begin
      int hold;
      bus.mode = 3'($urandom_range(0, 7));
      bus.HL   = 2'($urandom_range(0, 3));
      hold     = int'($urandom_range(50, 1500));
      for (int k = 0; k < hold; k++) begin
        if (k == hold / 2 && $urandom_range(0, 1) == 1)
          bus.HL = 2'($urandom_range(0, 3));
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
